// File: rtl/reg_write_arbiter_if.sv
// Bundle for reg_write_arbiter: requester handshakes, reg_file write port, read bypass path.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline.
interface reg_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 4
);
    localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREG  = 2 ** ADDR_W;

    logic                       hold;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_data;

    logic                       wr_en;
    logic [ADDR_W-1:0]          write_addr;
    logic [DATA_W-1:0]          write_data;
    logic [GID_W-1:0]           grant_id;
    logic [NREG-1:0]            busy_mask;

    logic [ADDR_W-1:0]          rd_addr1;
    logic [ADDR_W-1:0]          rd_addr2;
    logic [DATA_W-1:0]          rf_read_data1;
    logic [DATA_W-1:0]          rf_read_data2;
    logic [DATA_W-1:0]          rd_data1;
    logic [DATA_W-1:0]          rd_data2;

    modport master (
        output hold, req_valid, req_addr, req_data,
        output rd_addr1, rd_addr2, rf_read_data1, rf_read_data2,
        input  req_ready, wr_en, write_addr, write_data, grant_id, busy_mask,
        input  rd_data1, rd_data2
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        input  rd_addr1, rd_addr2, rf_read_data1, rf_read_data2,
        output req_ready, wr_en, write_addr, write_data, grant_id, busy_mask,
        output rd_data1, rd_data2
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the reg_file write port, with a one-cycle registered output stage.
// Optional macro REG_WR_BYPASS_EN forwards the in-flight write onto both read ports.
module reg_write_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_write_arbiter_if.slave   bus
);
    localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREG  = 2 ** ADDR_W;

    logic [GID_W-1:0]   last_q, last_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  write_addr_q, write_addr_d;
    logic [DATA_W-1:0]  write_data_q, write_data_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;

    logic               accept;
    logic [GID_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] ready;
    int unsigned        scan_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic [NREG-1:0]    busy_mask;

    // Scan from the requester after the last winner; the sum never exceeds 2*NUM_REQ-1,
    // so one conditional subtraction performs the wrap.
    always_comb begin
        accept    = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        if (!reset && !bus.hold) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan_idx = 32'(last_q) + 1 + k;
                if (scan_idx >= NUM_REQ) begin
                    scan_idx = scan_idx - NUM_REQ;
                end
                if (!accept && bus.req_valid[GID_W'(scan_idx)]) begin
                    accept    = 1'b1;
                    grant_idx = GID_W'(scan_idx);
                end
            end
        end
        ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    assign sel_addr = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data = bus.req_data[grant_idx*DATA_W +: DATA_W];

    always_comb begin
        wr_en_d      = accept;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        grant_id_d   = grant_id_q;
        last_d       = last_q;
        if (accept) begin
            write_addr_d = sel_addr;
            write_data_d = sel_data;
            grant_id_d   = grant_idx;
            last_d       = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q       <= GID_W'(NUM_REQ - 1);
            wr_en_q      <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            grant_id_q   <= '0;
        end else begin
            last_q       <= last_d;
            wr_en_q      <= wr_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            grant_id_q   <= grant_id_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        if (wr_en_q) begin
            busy_mask[write_addr_q] = 1'b1;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy_mask  = busy_mask;

`ifdef REG_WR_BYPASS_EN
    // reg_file commits one edge after wr_en, so its read data is stale for that address.
    assign bus.rd_data1 = (wr_en_q && (write_addr_q == bus.rd_addr1)) ? write_data_q
                                                                      : bus.rf_read_data1;
    assign bus.rd_data2 = (wr_en_q && (write_addr_q == bus.rd_addr2)) ? write_data_q
                                                                      : bus.rf_read_data2;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{bus.rd_addr1, bus.rd_addr2};
    assign bus.rd_data1   = bus.rf_read_data1;
    assign bus.rd_data2   = bus.rf_read_data2;
`endif

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares the single write port of the 16 x 32-bit register file (`reg_file`) between NUM_REQ requesters, e.g. ALU writeback and load writeback.
- Uses a valid/ready handshake per requester.
- Grants are round-robin.
- The accepted write is registered and driven onto the `reg_file` `wr_en`/`write_addr`/`write_data` inputs one cycle later.
- Sits between the execute/memory stages and `reg_file`. Also optionally forwards the in-flight write onto the read ports.

Parameters:
NUM_REQ, 2, number of write requesters (2..4)
DATA_W, 32, register data width
ADDR_W, 4, register address width (2**ADDR_W registers)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
hold  in  1  pipeline stall; when 1 no request is accepted
req_valid  in  NUM_REQ  request i presents a write
req_ready  out  NUM_REQ  request i accepted this cycle (one-hot or zero)
req_addr  in  NUM_REQ*ADDR_W  packed; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed; requester i at [i*DATA_W +: DATA_W]
wr_en  out  1  to reg_file wr_en
write_addr  out  ADDR_W  to reg_file write_addr
write_data  out  DATA_W  to reg_file write_data
grant_id  out  max(1,$clog2(NUM_REQ))  index of requester whose write is on wr_en
busy_mask  out  2**ADDR_W  one-hot of write_addr when wr_en=1, else 0
rd_addr1, rd_addr2  in  ADDR_W  consumer read addresses, passed to reg_file read_addr1/2
rf_read_data1, rf_read_data2  in  DATA_W  from reg_file read_data1/2
rd_data1, rd_data2  out  DATA_W  read data to consumers

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - wr_en=0, write_addr=0, write_data=0, grant_id=0, busy_mask=0.
  - RR pointer `last` = NUM_REQ-1, so requester 0 has first priority.
  - req_ready forced to 0 while reset=1.
- Arbitration (combinational, same cycle):
  - If hold=0, the first valid requester scanning from (last+1) mod NUM_REQ upward with wrap gets req_ready=1.
  - No valid requesters, or hold=1: req_ready all 0.
  - req_ready may depend on req_valid.
- Handshake: accept = req_valid[i] & req_ready[i].
  - Requesters hold valid/addr/data stable until accepted; withdrawing is illegal.
  - Back-to-back accepts are allowed; throughput is 1 write/cycle.
- Output stage, at the next posedge after an accept:
  - wr_en=1; write_addr/write_data/grant_id = accepted values; `last` = i.
  - reg_file commits at the following posedge, so total request-to-commit latency is 2 edges.
- No accept: at the next posedge wr_en=0; write_addr, write_data and grant_id hold their values; `last` unchanged.
- busy_mask: combinational decode of the registered stage.
- Same-address requests from several requesters in the same cycle are serialised in RR order; the last one written wins. No merging.
- Writes to any address, including 15, are legal; no address filtering.
- hold asserted while wr_en=1 does not cancel the write already in the output stage.
- rd_addr1/rd_addr2 connect straight to reg_file read_addr1/read_addr2 at the parent.

Optional Feature:
Macro REG_WR_BYPASS_EN.
- Defined: rdN_data = write_data when wr_en=1 and write_addr==rdN_addr, else rf_read_dataN. Each port is independent, and both ports may bypass in the same cycle.
- Undefined: rdN_data = rf_read_dataN, a pure pass-through with no comparators.
- Ports are identical in both builds.

Test Plan:
1. Reset, then req_valid=01, req_addr0=4'hA, req_data0=32'hFFFFFFFF for one cycle -> req_ready=01 the same cycle; next cycle wr_en=1, write_addr=A, write_data=FFFFFFFF, grant_id=0, busy_mask=16'h0400; cycle after, wr_en=0 and busy_mask=0.
2. Both valid continuously, req0 addr 4 data 32'h55555555, req1 addr 5 data 32'hAAAAAAAA, new data on each accept -> grants alternate 0,1,0,1 and wr_en stays 1 every cycle.
3. Both valid with hold=1 for 3 cycles -> req_ready=00 and wr_en=0 after the first cycle; release hold -> requester (last+1) is granted first.
4. Both valid, addr 4'hF, req0 data 0, req1 data 1 from reset -> write 0 to F, then 1 to F on consecutive cycles; reg_file R15 ends at 1.
5. Assert reset mid-burst between clock edges -> wr_en, req_ready and busy_mask drop to 0 immediately; after release with both valid, requester 0 is granted first.
6. With REG_WR_BYPASS_EN: wr_en=1, write_addr=4, write_data=32'h12345678, rd_addr1=4, rf_read_data1=0, rd_addr2=5, rf_read_data2=32'h9 -> rd_data1=12345678 and rd_data2=9. Without the macro -> rd_data1=0 and rd_data2=9.
